// File: rtl/output_config_sequencer.sv
// Output configuration sequencer: expands one channel command into the ordered
// CSR write burst (disable, delay, width, pattern words, mode) for a driver bank.
module output_config_sequencer #(
  parameter int CHANNEL_COUNT         = 8,
  parameter int SERDES_WIDTH          = 4,
  parameter int COARSE_DELAY_WIDTH    = 22,
  parameter int COARSE_WIDTH_WIDTH    = 20,
  parameter int PATTERN_ADDRESS_WIDTH = 13
) (
  input  logic                                         sysClk,
  input  logic                                         sysReset,
  input  logic                                         cmdValid,
  output logic                                         cmdReady,
  input  logic [4:0]                                   cmdChannel,
  input  logic [1:0]                                   cmdMode,
  input  logic [COARSE_DELAY_WIDTH+SERDES_WIDTH-1:0]   cmdDelay,
  input  logic [COARSE_WIDTH_WIDTH+SERDES_WIDTH-1:0]   cmdWidth,
  input  logic [PATTERN_ADDRESS_WIDTH:0]               cmdPatternLength,
  output logic [PATTERN_ADDRESS_WIDTH-1:0]             patRdAddr,
  input  logic [SERDES_WIDTH-1:0]                      patRdData,
  output logic [CHANNEL_COUNT-1:0]                     sysCsrStrobe,
  output logic [31:0]                                  sysGPIO_OUT,
  output logic                                         busy,
  output logic                                         doneStrobe,
  output logic                                         errorStrobe
);
  localparam int DelayW = COARSE_DELAY_WIDTH + SERDES_WIDTH;
  localparam int WidthW = COARSE_WIDTH_WIDTH + SERDES_WIDTH;
  localparam int AddrW  = PATTERN_ADDRESS_WIDTH;
  localparam int LenW   = AddrW + 1;
  localparam logic [LenW-1:0]  PatDepth  = {1'b1, {AddrW{1'b0}}};
  localparam logic [AddrW-1:0] AddrMax   = '1;
  localparam logic [5:0]       ChanLimit = 6'(CHANNEL_COUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_DISABLE, S_DELAY, S_WIDTH, S_PATTERN, S_MODE, S_DONE
  } stateT;

  stateT stateReg, stateNext;

  logic [4:0]               chanReg;
  logic [1:0]               modeReg;
  logic [DelayW-1:0]        delayReg;
  logic [WidthW-1:0]        widthReg;
  logic [LenW-1:0]          lenReg;
  logic [LenW-1:0]          lenClamped;
  logic [LenW-1:0]          patIdxReg, patIdxNext;
  logic [AddrW-1:0]         patAddrReg, patAddrNext;
  logic [CHANNEL_COUNT-1:0] strobeReg, strobeNext;
  logic [31:0]              wordReg, wordNext;
  logic                     patPhaseReg, patPhaseNext;
  logic                     writeNext;
  logic [4:0]               wordChan;
  logic                     busyReg, doneReg, errorReg, readyReg;
  logic                     accept, chanBad, patNeeded;

  assign accept     = cmdValid & readyReg;
  assign chanBad    = {1'b0, cmdChannel} >= ChanLimit;
  assign lenClamped = (cmdPatternLength > PatDepth) ? PatDepth : cmdPatternLength;
  assign patNeeded  = modeReg[1] && (lenReg != '0);

  // Next state plus the write that the next state will present on the bus.
  always_comb begin
    stateNext    = stateReg;
    wordNext     = '0;
    writeNext    = 1'b0;
    wordChan     = chanReg;
    patPhaseNext = 1'b0;
    patIdxNext   = patIdxReg;
    patAddrNext  = patAddrReg;

    case (stateReg)
      S_IDLE, S_DONE: begin
        if (accept) stateNext = chanBad ? S_DONE : S_DISABLE;
        else        stateNext = S_IDLE;
      end
      S_DISABLE: stateNext = S_DELAY;
      S_DELAY:   stateNext = S_WIDTH;
      S_WIDTH:   stateNext = patNeeded ? S_PATTERN : S_MODE;
      S_PATTERN: stateNext = (patIdxReg == lenReg - 1'b1) ? S_MODE : S_PATTERN;
      S_MODE:    stateNext = S_DONE;
      default:   stateNext = S_IDLE;
    endcase

    case (stateNext)
      S_DISABLE: begin
        writeNext = 1'b1;
        wordChan  = cmdChannel;
      end
      S_DELAY: begin
        writeNext = 1'b1;
        wordNext  = 32'h4000_0000 | 32'(delayReg);
      end
      S_WIDTH: begin
        writeNext   = 1'b1;
        wordNext    = 32'h8000_0000 | 32'(widthReg);
        patAddrNext = '0;
      end
      S_PATTERN: begin
        writeNext    = 1'b1;
        patPhaseNext = 1'b1;
        patIdxNext   = (stateReg == S_PATTERN) ? patIdxReg + 1'b1 : '0;
        patAddrNext  = (patAddrReg == AddrMax) ? AddrMax : patAddrReg + 1'b1;
        wordNext     = 32'hC000_0000 | (32'(patIdxNext[AddrW-1:0]) << 10);
      end
      S_MODE: begin
        writeNext = 1'b1;
        wordNext  = 32'(modeReg);
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_strobe
      assign strobeNext[gi] = writeNext && (wordChan == 5'(gi));
    end
  endgenerate

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      stateReg    <= S_IDLE;
      strobeReg   <= '0;
      wordReg     <= '0;
      patPhaseReg <= 1'b0;
      patIdxReg   <= '0;
      patAddrReg  <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      errorReg    <= 1'b0;
      readyReg    <= 1'b1;
    end else begin
      stateReg    <= stateNext;
      strobeReg   <= strobeNext;
      wordReg     <= wordNext;
      patPhaseReg <= patPhaseNext;
      patIdxReg   <= patIdxNext;
      patAddrReg  <= patAddrNext;
      busyReg     <= !(stateNext == S_IDLE || stateNext == S_DONE);
      doneReg     <= (stateNext == S_DONE);
      errorReg    <= accept && chanBad;
      readyReg    <= (stateNext == S_IDLE || stateNext == S_DONE);
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      chanReg  <= '0;
      modeReg  <= '0;
      delayReg <= '0;
      widthReg <= '0;
      lenReg   <= '0;
    end else if (accept) begin
      chanReg  <= cmdChannel;
      modeReg  <= cmdMode;
      delayReg <= cmdDelay;
      widthReg <= cmdWidth;
      lenReg   <= lenClamped;
    end
  end

  // Pattern data arrives one cycle after its address, so it is merged into the
  // registered header word in the strobe cycle rather than registered again.
  assign sysGPIO_OUT  = wordReg | (patPhaseReg ? 32'(patRdData) : 32'd0);
  assign sysCsrStrobe = strobeReg;
  assign patRdAddr    = patAddrReg;
  assign busy         = busyReg;
  assign doneStrobe   = doneReg;
  assign errorStrobe  = errorReg;
  assign cmdReady     = readyReg;

endmodule

// File: tb/tb_output_config_sequencer.sv
// Self-checking bench for output_config_sequencer: directed plan items plus random
// commands, each compared cycle by cycle against a write-list reference model.
module tb_output_config_sequencer;
  localparam int ChanCount = 8;
  localparam int SerW      = 4;
  localparam int DlyW      = 26;
  localparam int WidW      = 24;
  localparam int AddrW     = 13;
  localparam int Depth     = 8192;

  typedef struct packed {
    logic [4:0]      ch;
    logic [1:0]      mode;
    logic [DlyW-1:0] delay;
    logic [WidW-1:0] width;
    logic [AddrW:0]  len;
  } cmdT;

  logic                 sysClk = 1'b0;
  logic                 sysReset;
  logic                 cmdValid;
  logic                 cmdReady;
  logic [4:0]           cmdChannel;
  logic [1:0]           cmdMode;
  logic [DlyW-1:0]      cmdDelay;
  logic [WidW-1:0]      cmdWidth;
  logic [AddrW:0]       cmdPatternLength;
  logic [AddrW-1:0]     patRdAddr;
  logic [SerW-1:0]      patRdData;
  logic [ChanCount-1:0] sysCsrStrobe;
  logic [31:0]          sysGPIO_OUT;
  logic                 busy;
  logic                 doneStrobe;
  logic                 errorStrobe;

  logic [SerW-1:0] mem [Depth];
  int compareCount  = 0;
  int mismatchCount = 0;

  output_config_sequencer dut (
    .sysClk(sysClk), .sysReset(sysReset),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdChannel(cmdChannel), .cmdMode(cmdMode),
    .cmdDelay(cmdDelay), .cmdWidth(cmdWidth),
    .cmdPatternLength(cmdPatternLength),
    .patRdAddr(patRdAddr), .patRdData(patRdData),
    .sysCsrStrobe(sysCsrStrobe), .sysGPIO_OUT(sysGPIO_OUT),
    .busy(busy), .doneStrobe(doneStrobe), .errorStrobe(errorStrobe)
  );

  always #5 sysClk = ~sysClk;

  // Source memory with one cycle of read latency.
  always @(posedge sysClk) patRdData <= mem[patRdAddr];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic checkResult(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic cmdT mkCmd(int ch, int mode, logic [DlyW-1:0] delay,
                                logic [WidW-1:0] width, int len);
    cmdT c;
    c.ch = 5'(ch); c.mode = 2'(mode); c.delay = delay; c.width = width; c.len = 14'(len);
    return c;
  endfunction

  function automatic cmdT randCmd();
    int lenPick;
    lenPick = $urandom_range(0, 9);
    return mkCmd($urandom_range(0, 9), $urandom_range(0, 3), DlyW'($urandom), WidW'($urandom),
                 (lenPick == 0) ? 0 : $urandom_range(1, 24));
  endfunction

  // Reference: the word carried by write number w of a command with L pattern words.
  function automatic logic [31:0] expWord(cmdT c, int w, int L);
    if (w == 0) return 32'h0;
    if (w == 1) return 32'h4000_0000 | 32'(c.delay);
    if (w == 2) return 32'h8000_0000 | 32'(c.width);
    if (w < 3 + L) return 32'hC000_0000 | (32'(w - 3) << 10) | 32'(mem[w - 3]);
    return 32'(c.mode);
  endfunction

  task automatic drive(input cmdT c);
    cmdChannel = c.ch; cmdMode = c.mode; cmdDelay = c.delay;
    cmdWidth = c.width; cmdPatternLength = c.len;
  endtask

  task automatic startCmd(input cmdT c);
    @(posedge sysClk); #1;
    drive(c);
    cmdValid = 1'b1;
  endtask

  // Returns at the falling edge of the accept cycle (cycle 0).
  task automatic waitAccept();
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 100) begin
      @(negedge sysClk);
      if (cmdReady) seen = 1'b1;
      n++;
    end
    if (!seen) checkResult("acceptTimeout", 64'd0, 64'd1);
  endtask

  // Checks cycles 1..done (or 1..stopAt) after the accept; optionally holds the next command.
  task automatic checkCmd(input cmdT c, input bit holdNext, input cmdT nxt, input int stopAt);
    bit bad;
    int L, nW, D, last, expAddr;
    logic [ChanCount-1:0] expStrobe;
    bad  = (c.ch >= ChanCount);
    L    = (c.mode[1] && c.len != 0) ? ((c.len > Depth) ? Depth : int'(c.len)) : 0;
    nW   = bad ? 0 : 4 + L;
    D    = nW + 1;
    last = (stopAt > 0 && stopAt < D) ? stopAt : D;
    @(posedge sysClk); #1;
    if (holdNext) drive(nxt);
    else cmdValid = 1'b0;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(posedge sysClk);
      @(negedge sysClk);
      expStrobe = (k <= nW) ? ChanCount'(1 << c.ch) : '0;
      checkResult("strobe", 64'(sysCsrStrobe), 64'(expStrobe));
      if (k <= nW) checkResult("word", 64'(sysGPIO_OUT), 64'(expWord(c, k - 1, L)));
      checkResult("done",  64'(doneStrobe),  64'(k == D));
      checkResult("busy",  64'(busy),        64'(k < D));
      checkResult("ready", 64'(cmdReady),    64'(k == D));
      checkResult("error", 64'(errorStrobe), 64'(bad && k == 1));
      if (L > 0 && k == 3) checkResult("patAddr0", 64'(patRdAddr), 64'd0);
      if (L > 0 && k >= 4 && k <= 3 + L) begin
        expAddr = (k - 3 > Depth - 1) ? Depth - 1 : k - 3;
        checkResult("patAddr", 64'(patRdAddr), 64'(expAddr));
      end
    end
    if (stopAt == 0)
      $display("cmd ch=%0d mode=%0d len=%0d writes=%0d done_cycle=%0d err=%0d",
               c.ch, c.mode, c.len, nW, D, bad);
  endtask

  initial begin
    cmdT c, c2, nxt;
    bit held;

    sysReset = 1'b1;
    cmdValid = 1'b0;
    drive('0);
    for (int i = 0; i < Depth; i++) mem[i] = SerW'($urandom);

    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    checkResult("rstStrobe", 64'(sysCsrStrobe), 64'd0);
    checkResult("rstWord",   64'(sysGPIO_OUT),  64'd0);
    checkResult("rstAddr",   64'(patRdAddr),    64'd0);
    checkResult("rstBusy",   64'(busy),         64'd0);
    checkResult("rstDone",   64'(doneStrobe),   64'd0);
    checkResult("rstError",  64'(errorStrobe),  64'd0);
    checkResult("rstReady",  64'(cmdReady),     64'd1);
    @(posedge sysClk); #1;
    sysReset = 1'b0;

    // Pulse mode with a nonzero length still skips the pattern phase.
    c = mkCmd(2, 1, 26'h15, 24'h38, 5);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);

    mem[0] = 4'h1; mem[1] = 4'hF; mem[2] = 4'h8;
    c = mkCmd(0, 2, 26'h123, 24'h45, 3);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);

    c = mkCmd(7, 3, 26'h3FF_FFFF, 24'hFF_FFFF, 8192);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);
    c = mkCmd(5, 3, 26'h1, 24'h2, 9000);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);

    c = mkCmd(9, 1, 26'h7, 24'h7, 0);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);

    // Back-to-back: the second command waits on the bus through the whole first one.
    c  = mkCmd(3, 1, 26'hA, 24'hB, 0);
    c2 = mkCmd(4, 2, 26'hC, 24'hD, 4);
    startCmd(c); waitAccept(); checkCmd(c, 1'b1, c2, 0);
    checkCmd(c2, 1'b0, c2, 0);

    // Reset during cycle 5 of a 10-word load.
    c = mkCmd(1, 3, 26'h55, 24'h66, 10);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 4);
    @(posedge sysClk); #1;
    sysReset = 1'b1;
    @(negedge sysClk);
    checkResult("rstMidStrobe5", 64'(sysCsrStrobe), 64'h2);
    checkResult("rstMidWord5", 64'(sysGPIO_OUT), 64'(32'hC000_0400 | 32'(mem[1])));
    @(posedge sysClk); #1;
    sysReset = 1'b0;
    @(negedge sysClk);
    checkResult("rstMidStrobe6", 64'(sysCsrStrobe), 64'd0);
    checkResult("rstMidReady", 64'(cmdReady), 64'd1);
    checkResult("rstMidBusy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      checkResult("rstMidNoDone", 64'(doneStrobe), 64'd0);
      checkResult("rstMidNoStrobe", 64'(sysCsrStrobe), 64'd0);
      @(negedge sysClk);
    end
    $display("reset abort ch=1 len=10 at cycle 5");
    c = mkCmd(6, 1, 26'h99, 24'h88, 0);
    startCmd(c); waitAccept(); checkCmd(c, 1'b0, c, 0);

    held = 1'b0;
    c = randCmd();
    for (int n = 0; n < 30; n++) begin
      bit holdNext;
      if (!held) begin
        startCmd(c);
        waitAccept();
      end
      nxt = randCmd();
      holdNext = ($urandom_range(0, 2) == 0) && (n < 29);
      checkCmd(c, holdNext, nxt, 0);
      held = holdNext;
      c = nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
